// File: rtl/bus_ctrl_pkg.sv
// Shared encodings and default sizes for the bus transfer controller.
package bus_ctrl_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int NUM_REGS_DEF = 6;
    localparam int SEL_W_DEF    = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_WRITE   = 2'd3
    } bus_state_t;

    // True when a register index addresses one of the attached registers.
    function automatic logic idx_in_range(input int unsigned idx, input int unsigned num_regs);
        return idx < num_regs;
    endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Index plus enable to one-hot strobe vector; all zeros when disabled.
module reg_sel_decoder #(
    parameter int NUM_REGS = 6,
    parameter int SEL_W    = 3
) (
    input  logic [SEL_W-1:0]    i_sel,
    input  logic                i_en,
    output logic [NUM_REGS-1:0] o_onehot
);

    // Compare the select against every register slot.
    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            o_onehot[i] = i_en && (i_sel == SEL_W'(i));
        end
    end

endmodule

// File: rtl/bus_transfer_controller.sv
// Initiator for single-word register->register and immediate->register moves.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for xfer_req; validates indices, latches request
// READ     | rd_en[src] high; source register presents its word next cycle
// CAPTURE  | no strobes; source word latched into the capture register
// WRITE    | bus_out = capture register, wr_en[dst] high; done follows
module bus_transfer_controller
    import bus_ctrl_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int SEL_W    = SEL_W_DEF
) (
    input  logic                       bus_ctrl_clk,
    input  logic                       bus_ctrl_rst,
    input  logic                       xfer_req,
    input  logic                       xfer_imm,
    input  logic [SEL_W-1:0]           xfer_src,
    input  logic [SEL_W-1:0]           xfer_dst,
    input  logic [DATA_W-1:0]          xfer_imm_data,
    input  logic [NUM_REGS*DATA_W-1:0] reg_data_in,
    output logic [NUM_REGS-1:0]        reg_rd_en,
    output logic [NUM_REGS-1:0]        reg_wr_en,
    output logic [DATA_W-1:0]          bus_out,
    output logic                       xfer_busy,
    output logic                       xfer_done,
    output logic                       xfer_err
);

    bus_state_t        r_state;
    logic [SEL_W-1:0]  r_src;
    logic [SEL_W-1:0]  r_dst;
    logic [DATA_W-1:0] r_capture;
    logic              r_rd_go;
    logic              r_wr_go;
    logic              r_done;
    logic              r_err;

    logic              w_src_ok;
    logic              w_dst_ok;
    logic              w_req_valid;
    logic [DATA_W-1:0] w_src_word;

    // An immediate move never reads, so its source field is not checked.
    always_comb begin
        w_src_ok    = idx_in_range(32'(xfer_src), NUM_REGS);
        w_dst_ok    = idx_in_range(32'(xfer_dst), NUM_REGS);
        w_req_valid = w_dst_ok && (xfer_imm || w_src_ok);
    end

    // Select the latched source register's word from the packed input bus.
    always_comb begin
        w_src_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_src == SEL_W'(i)) begin
                w_src_word = reg_data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // Sequencer: state, latched request, capture register and registered strobe enables.
    always_ff @(posedge bus_ctrl_clk) begin
        if (bus_ctrl_rst) begin
            r_state   <= ST_IDLE;
            r_src     <= '0;
            r_dst     <= '0;
            r_capture <= '0;
            r_rd_go   <= 1'b0;
            r_wr_go   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_rd_go <= 1'b0;
            r_wr_go <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (xfer_req) begin
                        if (w_req_valid) begin
                            r_src <= xfer_src;
                            r_dst <= xfer_dst;
                            if (xfer_imm) begin
                                r_capture <= xfer_imm_data;
                                r_wr_go   <= 1'b1;
                                r_state   <= ST_WRITE;
                            end else begin
                                r_rd_go <= 1'b1;
                                r_state <= ST_READ;
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // Source register output became valid at the end of READ.
                    r_capture <= w_src_word;
                    r_wr_go   <= 1'b1;
                    r_state   <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    reg_sel_decoder #(
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W)
    ) u_rd_dec (
        .i_sel    (r_src),
        .i_en     (r_rd_go),
        .o_onehot (reg_rd_en)
    );

    reg_sel_decoder #(
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W)
    ) u_wr_dec (
        .i_sel    (r_dst),
        .i_en     (r_wr_go),
        .o_onehot (reg_wr_en)
    );

    // The capture register drives the write bus directly, so it holds between transfers.
    always_comb begin
        bus_out   = r_capture;
        xfer_busy = (r_state != ST_IDLE);
        xfer_done = r_done;
        xfer_err  = r_err;
    end

endmodule

// File: tb/tb_bus_transfer_controller.sv
// Directed bench for bus_transfer_controller with a behavioural register file.
module tb_bus_transfer_controller;

    localparam int DW = 16;
    localparam int NR = 6;
    localparam int SW = 3;

    logic              clk;
    logic              rst;
    logic              req;
    logic              imm;
    logic [SW-1:0]     src;
    logic [SW-1:0]     dst;
    logic [DW-1:0]     imm_data;
    logic [NR*DW-1:0]  reg_data;
    logic [NR-1:0]     rd_en;
    logic [NR-1:0]     wr_en;
    logic [DW-1:0]     bus_out;
    logic              busy;
    logic              done;
    logic              err;

    logic              m_clr;
    logic              pre_en;
    logic [SW-1:0]     pre_idx;
    logic [DW-1:0]     pre_val;
    logic [DW-1:0]     m_store [NR];
    logic [DW-1:0]     m_out   [NR];

    int n_checks = 0;
    int n_errors = 0;

    bus_transfer_controller dut (
        .bus_ctrl_clk  (clk),
        .bus_ctrl_rst  (rst),
        .xfer_req      (req),
        .xfer_imm      (imm),
        .xfer_src      (src),
        .xfer_dst      (dst),
        .xfer_imm_data (imm_data),
        .reg_data_in   (reg_data),
        .reg_rd_en     (rd_en),
        .reg_wr_en     (wr_en),
        .bus_out       (bus_out),
        .xfer_busy     (busy),
        .xfer_done     (done),
        .xfer_err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register model: capture on wr_en, present stored value one clock after rd_en.
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (m_clr) begin
                m_store[i] <= '0;
                m_out[i]   <= '0;
            end else begin
                if (wr_en[i]) m_store[i] <= bus_out;
                else if (pre_en && pre_idx == SW'(i)) m_store[i] <= pre_val;
                if (rd_en[i]) m_out[i] <= m_store[i];
            end
        end
    end

    always_comb begin
        reg_data = '0;
        for (int i = 0; i < NR; i++) reg_data[i*DW +: DW] = m_out[i];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; imm = 1'b0; src = '0; dst = '0; imm_data = '0;
        m_clr = 1'b1; pre_en = 1'b0; pre_idx = '0; pre_val = '0;
        step(2);
        rst = 1'b0; m_clr = 1'b0;
        step(5);
        check("rst_rd_en", 32'(rd_en), 32'h0);
        check("rst_wr_en", 32'(wr_en), 32'h0);
        check("rst_bus_out", 32'(bus_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);

        // Preload reg2 and reg5.
        pre_en = 1'b1; pre_idx = 3'd2; pre_val = 16'hA5C3;
        step(1);
        pre_idx = 3'd5; pre_val = 16'hBEEF;
        step(1);
        pre_en = 1'b0;

        // Register transfer reg2 -> reg4.
        req = 1'b1; imm = 1'b0; src = 3'd2; dst = 3'd4;
        step(1); req = 1'b0;
        check("r2r_p1_rd_en", 32'(rd_en), 32'b000100);
        check("r2r_p1_wr_en", 32'(wr_en), 32'h0);
        check("r2r_p1_busy", 32'(busy), 32'h1);
        step(1);
        check("r2r_p2_rd_en", 32'(rd_en), 32'h0);
        check("r2r_p2_wr_en", 32'(wr_en), 32'h0);
        step(1);
        check("r2r_p3_wr_en", 32'(wr_en), 32'b010000);
        check("r2r_p3_bus_out", 32'(bus_out), 32'hA5C3);
        check("r2r_p3_rd_en", 32'(rd_en), 32'h0);
        check("r2r_p3_done", 32'(done), 32'h0);
        step(1);
        check("r2r_p4_done", 32'(done), 32'h1);
        check("r2r_p4_busy", 32'(busy), 32'h0);
        check("r2r_p4_wr_en", 32'(wr_en), 32'h0);
        check("r2r_reg4", 32'(m_store[4]), 32'hA5C3);

        // Immediate 0x1234 -> reg0, issued in the done cycle.
        req = 1'b1; imm = 1'b1; src = 3'd7; dst = 3'd0; imm_data = 16'h1234;
        step(1); req = 1'b0;
        check("imm_p1_wr_en", 32'(wr_en), 32'b000001);
        check("imm_p1_bus_out", 32'(bus_out), 32'h1234);
        check("imm_p1_rd_en", 32'(rd_en), 32'h0);
        check("imm_p1_busy", 32'(busy), 32'h1);
        step(1);
        check("imm_p2_done", 32'(done), 32'h1);
        check("imm_p2_busy", 32'(busy), 32'h0);
        check("imm_p2_rd_en", 32'(rd_en), 32'h0);
        check("imm_reg0", 32'(m_store[0]), 32'h1234);
        step(1);
        check("imm_p3_done", 32'(done), 32'h0);

        // Invalid destination.
        req = 1'b1; imm = 1'b1; dst = 3'd7; imm_data = 16'hDEAD;
        step(1); req = 1'b0;
        check("err_dst_err", 32'(err), 32'h1);
        check("err_dst_busy", 32'(busy), 32'h0);
        check("err_dst_strobes", 32'({rd_en, wr_en}), 32'h0);
        step(1);
        check("err_dst_pulse_end", 32'(err), 32'h0);
        check("err_dst_bus_hold", 32'(bus_out), 32'h1234);

        // Invalid source on a register transfer.
        req = 1'b1; imm = 1'b0; src = 3'd6; dst = 3'd1;
        step(1); req = 1'b0;
        check("err_src_err", 32'(err), 32'h1);
        check("err_src_busy", 32'(busy), 32'h0);
        check("err_src_strobes", 32'({rd_en, wr_en}), 32'h0);
        step(1);
        check("err_src_pulse_end", 32'(err), 32'h0);
        check("err_src_busy2", 32'(busy), 32'h0);

        // Request while busy is ignored: reg4 -> reg1, stray immediate at +2.
        req = 1'b1; imm = 1'b0; src = 3'd4; dst = 3'd1;
        step(1); req = 1'b0;
        check("ign_p1_rd_en", 32'(rd_en), 32'b010000);
        step(1);
        req = 1'b1; imm = 1'b1; dst = 3'd5; imm_data = 16'hFFFF;
        step(1); req = 1'b0;
        check("ign_p3_wr_en", 32'(wr_en), 32'b000010);
        check("ign_p3_bus_out", 32'(bus_out), 32'hA5C3);
        step(1);
        check("ign_p4_done", 32'(done), 32'h1);
        check("ign_p4_busy", 32'(busy), 32'h0);
        check("ign_p4_strobes", 32'({rd_en, wr_en}), 32'h0);
        check("ign_reg1", 32'(m_store[1]), 32'hA5C3);
        step(1);
        check("ign_p5_busy", 32'(busy), 32'h0);
        check("ign_reg5", 32'(m_store[5]), 32'hBEEF);

        // Request held through the done cycle: reg0 -> reg3 twice.
        req = 1'b1; imm = 1'b0; src = 3'd0; dst = 3'd3;
        step(1);
        check("held_p1_rd_en", 32'(rd_en), 32'b000001);
        step(2);
        check("held_p3_wr_en", 32'(wr_en), 32'b001000);
        check("held_p3_bus_out", 32'(bus_out), 32'h1234);
        step(1);
        check("held_p4_done", 32'(done), 32'h1);
        check("held_p4_busy", 32'(busy), 32'h0);
        step(1); req = 1'b0;
        check("held_p5_rd_en", 32'(rd_en), 32'b000001);
        check("held_p5_busy", 32'(busy), 32'h1);
        check("held_p5_done", 32'(done), 32'h0);
        step(2);
        check("held_p7_wr_en", 32'(wr_en), 32'b001000);
        step(1);
        check("held_p8_done", 32'(done), 32'h1);
        check("held_reg3", 32'(m_store[3]), 32'h1234);

        // Reset during CAPTURE: reg5 -> reg2 must not complete.
        req = 1'b1; imm = 1'b0; src = 3'd5; dst = 3'd2;
        step(1); req = 1'b0;
        check("rstc_p1_rd_en", 32'(rd_en), 32'b100000);
        step(1);
        check("rstc_p2_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rstc_p3_busy", 32'(busy), 32'h0);
        check("rstc_p3_wr_en", 32'(wr_en), 32'h0);
        check("rstc_p3_bus_out", 32'(bus_out), 32'h0);
        check("rstc_p3_done", 32'(done), 32'h0);
        step(1);
        check("rstc_p4_done", 32'(done), 32'h0);
        check("rstc_p4_wr_en", 32'(wr_en), 32'h0);
        check("rstc_reg2", 32'(m_store[2]), 32'hA5C3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
